// File: rtl/usr_pkg.sv
// usr_pkg: shared mode codes, FSM state type and the next-value function for univ_shift_reg
package usr_pkg;
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHR  = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_LOAD = 3'd3;
    localparam logic [2:0] MODE_ROTR = 3'd4;
    localparam logic [2:0] MODE_ROTL = 3'd5;
    localparam int USR_MAX_W = 64;

    typedef enum logic {ST_IDLE, ST_BURST} usr_state_t;

    // Operates on a zero-extended w-bit value so one function serves every WIDTH up to USR_MAX_W.
    function automatic logic [USR_MAX_W-1:0] usr_next(
        input logic [USR_MAX_W-1:0] q,
        input logic [2:0]           mode,
        input logic                 sin_msb,
        input logic                 sin_lsb,
        input logic [USR_MAX_W-1:0] pin,
        input int unsigned          w
    );
        logic [USR_MAX_W-1:0] msk, top, one;
        one = USR_MAX_W'(1);
        msk = ~({USR_MAX_W{1'b1}} << w);
        top = one << (w - 1);
        return mode == MODE_SHR  ? (q >> 1) | (sin_msb ? top : '0) :
               mode == MODE_SHL  ? ((q << 1) | USR_MAX_W'(sin_lsb)) & msk :
               mode == MODE_LOAD ? pin & msk :
               mode == MODE_ROTR ? (q >> 1) | (q[0] ? top : '0) :
               mode == MODE_ROTL ? ((q << 1) | ((q >> (w - 1)) & one)) & msk :
               q;
    endfunction
endpackage

// File: rtl/usr_burst_ctrl.sv
// usr_burst_ctrl: burst FSM selecting the effective mode and update enable for the shift register
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [2:0]       eff_mode,
    output logic             upd_en,
    output logic             busy,
    output logic             done
);
    usr_state_t state, state_n;
    logic [2:0] bmode, bmode_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            bmode <= MODE_HOLD;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            bmode <= bmode_n;
            cnt   <= cnt_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        bmode_n = bmode;
        cnt_n   = cnt;
        done_n  = 1'b0;
        if (state == ST_IDLE) begin
            if (burst_start && burst_len != '0) begin
                state_n = ST_BURST;
                bmode_n = mode;
                cnt_n   = burst_len;
            end else begin
                done_n = burst_start;
            end
        end else begin
            cnt_n = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
        end
    end

    // A captured LOAD must not reload pin during the burst; reserved codes already hold.
    assign eff_mode = state == ST_BURST ? (bmode == MODE_LOAD ? MODE_HOLD : bmode) : mode;
    assign upd_en   = state == ST_BURST || !burst_start;
    assign busy     = state == ST_BURST;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with a counted burst controller
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] pin,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);
    logic [2:0] eff_mode;
    logic upd_en;
    logic [WIDTH-1:0] q_n;

    usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .burst_start(burst_start),
        .burst_len(burst_len),
        .eff_mode(eff_mode),
        .upd_en(upd_en),
        .busy(busy),
        .done(done)
    );

    assign q_n = WIDTH'(usr_next(USR_MAX_W'(q), eff_mode, sin_msb, sin_lsb, USR_MAX_W'(pin), WIDTH));

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (upd_en) q <= q_n;
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed and randomized checks of univ_shift_reg against a behavioural model
module tb_univ_shift_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] mode = 3'd0;
    logic sin_msb = 1'b0, sin_lsb = 1'b0;
    logic [7:0] pin = 8'd0;
    logic burst_start = 1'b0;
    logic [3:0] burst_len = 4'd0;
    logic [7:0] q;
    logic sout_r, sout_l, busy, done;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;
    int mq = 0, mleft = 0, mbm = 0;
    bit mdone = 1'b0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sin_msb(sin_msb), .sin_lsb(sin_lsb),
        .pin(pin), .burst_start(burst_start), .burst_len(burst_len),
        .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mnext(input int v, input int m, input bit sm, input bit sl, input int p);
        case (m)
            1: return (v / 2) + (sm ? 128 : 0);
            2: return ((v * 2) % 256) + (sl ? 1 : 0);
            3: return p;
            4: return (v / 2) + (v % 2) * 128;
            5: return ((v * 2) % 256) + (v / 128);
            default: return v;
        endcase
    endfunction

    task automatic model_step();
        if (rst) begin
            mq = 0; mleft = 0; mdone = 0;
        end else if (mleft > 0) begin
            if (mbm inside {1, 2, 4, 5}) mq = mnext(mq, mbm, sin_msb, sin_lsb, 0);
            mleft--;
            mdone = (mleft == 0);
        end else begin
            mdone = 0;
            if (burst_start && burst_len == 0) mdone = 1;
            else if (burst_start) begin
                mleft = burst_len;
                mbm = mode;
            end else mq = mnext(mq, mode, sin_msb, sin_lsb, pin);
        end
    endtask

    task automatic step(input bit r, input int m, input bit sm, input bit sl, input int p,
                        input bit bs, input int bl);
        @(negedge clk);
        rst = r; mode = m[2:0]; sin_msb = sm; sin_lsb = sl; pin = p[7:0];
        burst_start = bs; burst_len = bl[3:0];
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic lit(input string nm, input int eq, input int eb, input int ed);
        chk({nm, "_q"}, q, eq);
        chk({nm, "_busy"}, busy, eb);
        chk({nm, "_done"}, done, ed);
        chk({nm, "_model_q"}, mq, eq);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_q", q, mq);
            chk("cyc_busy", busy, mleft > 0 ? 1 : 0);
            chk("cyc_done", done, mdone);
            chk("cyc_sout_r", sout_r, mq % 2);
            chk("cyc_sout_l", sout_l, mq / 128);
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        lit("reset", 8'h00, 0, 0);
        step(0, 3, 0, 0, 8'hFF, 0, 0);
        lit("load_ff", 8'hFF, 0, 0);
        step(1, 3, 0, 0, 8'hFF, 0, 0);
        lit("rst_after_load", 8'h00, 0, 0);

        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        lit("shr4", 8'h60, 0, 0);
        chk("shr4_sout_r", sout_r, 0);
        repeat (4) step(0, 1, 0, 0, 0, 0, 0);
        chk("shr8_sout_r", sout_r, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0, 0);
        lit("shr10", 8'h01, 0, 0);
        chk("shr10_sout_r", sout_r, 1);

        step(0, 3, 0, 0, 8'hA5, 0, 0);
        lit("load_a5", 8'hA5, 0, 0);
        step(0, 5, 0, 0, 0, 0, 0);
        lit("rotl", 8'h4B, 0, 0);
        step(0, 3, 0, 0, 8'hA5, 0, 0);
        step(0, 4, 0, 0, 0, 0, 0);
        lit("rotr", 8'hD2, 0, 0);
        step(0, 3, 0, 0, 8'hA5, 0, 0);
        step(0, 2, 0, 1, 0, 0, 0);
        lit("shl1", 8'h4B, 0, 0);

        step(0, 3, 0, 0, 8'h81, 0, 0);
        step(0, 2, 0, 0, 0, 1, 3);
        lit("b3_accept", 8'h81, 1, 0);
        step(0, 3, 0, 0, 8'hFF, 0, 0);
        lit("b3_1", 8'h02, 1, 0);
        step(0, 3, 0, 0, 8'hFF, 0, 0);
        lit("b3_2", 8'h04, 1, 0);
        step(0, 3, 0, 0, 8'hFF, 0, 0);
        lit("b3_3", 8'h08, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        lit("b3_after", 8'h08, 0, 0);

        step(0, 2, 0, 1, 0, 1, 0);
        lit("len0", 8'h08, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        lit("len0_after", 8'h08, 0, 0);

        step(0, 3, 0, 0, 8'h01, 0, 0);
        step(0, 4, 0, 0, 0, 1, 2);
        lit("b2_accept", 8'h01, 1, 0);
        step(0, 4, 0, 0, 0, 1, 2);
        lit("b2_1", 8'h80, 1, 0);
        step(0, 4, 0, 0, 0, 1, 2);
        lit("b2_2", 8'h40, 0, 1);
        step(0, 4, 0, 0, 0, 1, 2);
        lit("b2_reaccept", 8'h40, 1, 0);
        step(1, 4, 0, 0, 0, 1, 2);
        lit("rst_mid_burst", 8'h00, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        lit("rst_no_done", 8'h00, 0, 0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 255), $urandom_range(0, 3) == 0, $urandom_range(0, 10));

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
